// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its issue stage.
// Holds the opcode map (also used by the ALU itself), the reserved
// opcode range, the data width and the issue FSM state encoding.
package alu_pkg;

  localparam int unsigned ALU_DW = 8;

  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_SUB    = 4'h1;
  localparam logic [3:0] ALU_MUL    = 4'h2;
  localparam logic [3:0] ALU_SHL    = 4'h3;
  localparam logic [3:0] ALU_SHR    = 4'h4;
  localparam logic [3:0] ALU_INC_A  = 4'h5;
  localparam logic [3:0] ALU_INC_B  = 4'h6;
  localparam logic [3:0] ALU_DEC_A  = 4'h7;
  localparam logic [3:0] ALU_DEC_B  = 4'h8;
  localparam logic [3:0] ALU_EQ     = 4'h9;
  localparam logic [3:0] ALU_GT     = 4'hA;
  localparam logic [3:0] ALU_LT     = 4'hB;
  localparam logic [3:0] ALU_RSV_LO = 4'hC;
  localparam logic [3:0] ALU_RSV_HI = 4'hE;
  localparam logic [3:0] ALU_NOP    = 4'hF;

  typedef enum logic {
    ST_IDLE,
    ST_EXEC
  } issue_state_t;

  // True for opcodes that really go through the ALU (not reserved, not NOP).
  function automatic logic is_alu_op(input logic [3:0] op);
    return op < ALU_RSV_LO;
  endfunction

endpackage

// File: rtl/alu_operand_regs.sv
// A/B operand register pair.
//   CLK, RESET   : clock, synchronous active-high reset (both regs -> 0)
//   WR_EN        : write strobe
//   WR_SEL       : 0 = write A, 1 = write B
//   WR_DATA      : value written
//   REG_A, REG_B : current register contents
module alu_operand_regs
  import alu_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WR_EN,
  input  logic              WR_SEL,
  input  logic [ALU_DW-1:0] WR_DATA,
  output logic [ALU_DW-1:0] REG_A,
  output logic [ALU_DW-1:0] REG_B
);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      REG_A <= '0;
      REG_B <= '0;
    end else if (WR_EN) begin
      if (WR_SEL) REG_B <= WR_DATA;
      else        REG_A <= WR_DATA;
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Operand-holding issue stage in front of the 8-bit ALU.
// Accepts load / ALU commands over a valid/ready handshake, drives the
// ALU inputs for issued operations, waits ALU_LATENCY edges and writes
// the ALU result back into A or B.
//   CLK, RESET          : clock, synchronous active-high reset
//   CMD_VALID/CMD_READY : command handshake
//   CMD_LOAD/OP/DST/IMM : command fields
//   ALU_IN_A/B, ALU_OP_CODE, ALU_OUT : ALU connection
//   REG_A, REG_B        : operand registers
//   RESULT              : last captured ALU result
//   DONE                : one-cycle completion pulse
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_LOAD,
  input  logic [3:0]        CMD_OP,
  input  logic              CMD_DST,
  input  logic [ALU_DW-1:0] CMD_IMM,
  output logic [ALU_DW-1:0] ALU_IN_A,
  output logic [ALU_DW-1:0] ALU_IN_B,
  output logic [3:0]        ALU_OP_CODE,
  input  logic [ALU_DW-1:0] ALU_OUT,
  output logic [ALU_DW-1:0] REG_A,
  output logic [ALU_DW-1:0] REG_B,
  output logic [ALU_DW-1:0] RESULT,
  output logic              DONE
);

  localparam int unsigned CW = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

  issue_state_t      state_q, state_n;
  logic [CW-1:0]     cnt_q;
  logic              dst_q;
  logic              issue, capture, done_n;
  logic              wr_en, wr_sel;
  logic [ALU_DW-1:0] wr_data;

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    CMD_READY = 1'b0;
    issue     = 1'b0;
    capture   = 1'b0;
    done_n    = 1'b0;
    wr_en     = 1'b0;
    wr_sel    = CMD_DST;
    wr_data   = CMD_IMM;
    case (state_q)
      ST_IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) begin
          if (CMD_LOAD) begin
            wr_en  = 1'b1;
            done_n = 1'b1;
          end else if (is_alu_op(CMD_OP)) begin
            issue   = 1'b1;
            state_n = ST_EXEC;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          wr_en   = 1'b1;
          wr_sel  = dst_q;
          wr_data = ALU_OUT;
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q       <= '0;
      dst_q       <= 1'b0;
      ALU_IN_A    <= '0;
      ALU_IN_B    <= '0;
      ALU_OP_CODE <= ALU_NOP;
      RESULT      <= '0;
      DONE        <= 1'b0;
    end else begin
      DONE <= done_n;
      if (issue) begin
        ALU_IN_A    <= REG_A;
        ALU_IN_B    <= REG_B;
        ALU_OP_CODE <= CMD_OP;
        dst_q       <= CMD_DST;
        cnt_q       <= CW'(ALU_LATENCY);
      end else if (capture) begin
        RESULT      <= ALU_OUT;
        ALU_OP_CODE <= ALU_NOP;
      end else if (state_q == ST_EXEC) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  alu_operand_regs u_regs (
    .CLK     (CLK),
    .RESET   (RESET),
    .WR_EN   (wr_en),
    .WR_SEL  (wr_sel),
    .WR_DATA (wr_data),
    .REG_A   (REG_A),
    .REG_B   (REG_B)
  );

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: instance 0 uses ALU_LATENCY=1 with a registered
// ALU model, instance 1 uses ALU_LATENCY=0 with a combinational ALU model.
module tb_alu_issue_unit;

  logic       CLK = 1'b0;
  logic       rst;
  logic       cv [2];
  logic       cl [2];
  logic [3:0] co [2];
  logic       cd [2];
  logic [7:0] ci [2];
  logic       rdy [2];
  logic [7:0] ain [2];
  logic [7:0] bin [2];
  logic [3:0] aop [2];
  logic [7:0] aout [2];
  logic [7:0] ra [2];
  logic [7:0] rb [2];
  logic [7:0] res [2];
  logic       done [2];

  logic [7:0] mA [2];
  logic [7:0] mB [2];
  logic [7:0] mR [2];

  int n_total = 0;
  int n_bad   = 0;

  always #5 CLK = ~CLK;

  // Spec-level ALU arithmetic, used by the ALU stand-ins and the model.
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [15:0] p;
    p = a * b;
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return p[7:0];
      4'h3: return a << 1;
      4'h4: return a >> 1;
      4'h5: return a + 8'd1;
      4'h6: return b + 8'd1;
      4'h7: return a - 8'd1;
      4'h8: return b - 8'd1;
      4'h9: return (a == b) ? 8'h01 : 8'h00;
      4'hA: return (a > b) ? 8'h01 : 8'h00;
      4'hB: return (a < b) ? 8'h01 : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0] alu_q;
  always @(posedge CLK) alu_q <= alu_f(aop[0], ain[0], bin[0]);
  assign aout[0] = alu_q;
  assign aout[1] = alu_f(aop[1], ain[1], bin[1]);

  alu_issue_unit #(.ALU_LATENCY(1)) u_dut1 (
    .CLK(CLK), .RESET(rst), .CMD_VALID(cv[0]), .CMD_READY(rdy[0]),
    .CMD_LOAD(cl[0]), .CMD_OP(co[0]), .CMD_DST(cd[0]), .CMD_IMM(ci[0]),
    .ALU_IN_A(ain[0]), .ALU_IN_B(bin[0]), .ALU_OP_CODE(aop[0]), .ALU_OUT(aout[0]),
    .REG_A(ra[0]), .REG_B(rb[0]), .RESULT(res[0]), .DONE(done[0])
  );

  alu_issue_unit #(.ALU_LATENCY(0)) u_dut0 (
    .CLK(CLK), .RESET(rst), .CMD_VALID(cv[1]), .CMD_READY(rdy[1]),
    .CMD_LOAD(cl[1]), .CMD_OP(co[1]), .CMD_DST(cd[1]), .CMD_IMM(ci[1]),
    .ALU_IN_A(ain[1]), .ALU_IN_B(bin[1]), .ALU_OP_CODE(aop[1]), .ALU_OUT(aout[1]),
    .REG_A(ra[1]), .REG_B(rb[1]), .RESULT(res[1]), .DONE(done[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_models();
    for (int d = 0; d < 2; d++) begin
      mA[d] = 8'h00; mB[d] = 8'h00; mR[d] = 8'h00;
    end
  endtask

  // Send one command, wait for its DONE and compare against the model.
  task automatic do_cmd(input int d, input logic ld, input logic [3:0] op,
                        input logic dst, input logic [7:0] imm);
    int         k;
    int         lat;
    bit         issue;
    logic [7:0] ea, eb, r;
    issue = !ld && (op <= 4'hB);
    lat   = (d == 0) ? 1 : 0;
    ea    = mA[d];
    eb    = mB[d];
    @(negedge CLK);
    cv[d] = 1'b1; cl[d] = ld; co[d] = op; cd[d] = dst; ci[d] = imm;
    k = 0;
    while (!rdy[d] && k < 20) begin
      @(negedge CLK);
      k++;
    end
    if (!rdy[d]) check("ready_timeout", 32'(rdy[d]), 32'd1);
    @(posedge CLK); #1;
    cv[d] = 1'b0;
    if (ld) begin
      if (dst) mB[d] = imm; else mA[d] = imm;
    end else if (issue) begin
      r = alu_f(op, ea, eb);
      mR[d] = r;
      if (dst) mB[d] = r; else mA[d] = r;
    end
    k = 0;
    while (!done[d] && k < 20) begin
      if (issue) begin
        check("busy_ready", 32'(rdy[d]), 32'd0);
        check("alu_in_a", 32'(ain[d]), 32'(ea));
        check("alu_in_b", 32'(bin[d]), 32'(eb));
        check("alu_opcode", 32'(aop[d]), 32'(op));
      end
      @(posedge CLK); #1;
      k++;
    end
    check("done_latency", k, issue ? lat + 1 : 0);
    check("reg_a", 32'(ra[d]), 32'(mA[d]));
    check("reg_b", 32'(rb[d]), 32'(mB[d]));
    check("result", 32'(res[d]), 32'(mR[d]));
    check("idle_opcode", 32'(aop[d]), 32'hF);
    check("idle_ready", 32'(rdy[d]), 32'd1);
    @(posedge CLK); #1;
    check("done_single", 32'(done[d]), 32'd0);
  endtask

  int acc_i;
  int pulses;
  bit acc;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cv[d] = 1'b0; cl[d] = 1'b0; co[d] = 4'h0; cd[d] = 1'b0; ci[d] = 8'h00;
    end
    clear_models();
    repeat (3) @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_reg_a", 32'(ra[d]), 32'd0);
      check("rst_reg_b", 32'(rb[d]), 32'd0);
      check("rst_result", 32'(res[d]), 32'd0);
      check("rst_opcode", 32'(aop[d]), 32'hF);
      check("rst_done", 32'(done[d]), 32'd0);
    end
    rst = 1'b0;
    @(posedge CLK); #1;
    for (int d = 0; d < 2; d++) check("rst_ready", 32'(rdy[d]), 32'd1);

    // Back-to-back loads, then the directed ALU sequence on both latencies.
    for (int d = 0; d < 2; d++) begin
      @(negedge CLK);
      cv[d] = 1'b1; cl[d] = 1'b1; cd[d] = 1'b0; ci[d] = 8'h05;
      @(posedge CLK); #1;
      check("b2b_reg_a", 32'(ra[d]), 32'h05);
      check("b2b_done1", 32'(done[d]), 32'd1);
      cd[d] = 1'b1; ci[d] = 8'h03;
      @(posedge CLK); #1;
      cv[d] = 1'b0;
      check("b2b_reg_b", 32'(rb[d]), 32'h03);
      check("b2b_done2", 32'(done[d]), 32'd1);
      mA[d] = 8'h05; mB[d] = 8'h03;
      do_cmd(d, 1'b0, 4'h0, 1'b0, 8'h00);   // ADD -> A=08
      check("add_a", 32'(ra[d]), 32'h08);
      do_cmd(d, 1'b0, 4'h1, 1'b1, 8'h00);   // SUB -> B=05
      check("sub_b", 32'(rb[d]), 32'h05);
      do_cmd(d, 1'b0, 4'hA, 1'b0, 8'h00);   // GT  -> A=01
      check("gt_a", 32'(ra[d]), 32'h01);
      do_cmd(d, 1'b0, 4'hB, 1'b1, 8'h00);   // LT  -> B=01
      check("lt_b", 32'(rb[d]), 32'h01);
      do_cmd(d, 1'b1, 4'h0, 1'b0, 8'h05);
      do_cmd(d, 1'b0, 4'hC, 1'b0, 8'h00);   // reserved
      do_cmd(d, 1'b0, 4'hF, 1'b1, 8'h00);   // NOP
      check("nop_a", 32'(ra[d]), 32'h05);
    end

    // INC A held on the bus while MUL executes (latency-1 instance).
    do_cmd(0, 1'b1, 4'h0, 1'b0, 8'h02);
    do_cmd(0, 1'b1, 4'h0, 1'b1, 8'h03);
    @(negedge CLK);
    cv[0] = 1'b1; cl[0] = 1'b0; co[0] = 4'h2; cd[0] = 1'b0;
    @(posedge CLK); #1;
    co[0] = 4'h5;
    pulses = 0; acc = 1'b0; acc_i = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (done[0]) pulses++;
      if (!acc && rdy[0]) begin
        check("hold_a_mid", 32'(ra[0]), 32'h06);
        acc_i = i;
        acc = 1'b1;
        @(posedge CLK); #1;
        cv[0] = 1'b0;
      end
    end
    check("hold_accept_cycle", acc_i, 2);
    check("hold_done_pulses", pulses, 2);
    check("hold_final_a", 32'(ra[0]), 32'h07);
    mA[0] = 8'h07; mR[0] = 8'h06;

    // Randomized commands against the model.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 60; n++) begin
        do_cmd(d, ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end
    end

    // Reset in the middle of an ADD.
    do_cmd(0, 1'b1, 4'h0, 1'b0, 8'h11);
    @(negedge CLK);
    cv[0] = 1'b1; cl[0] = 1'b0; co[0] = 4'h0; cd[0] = 1'b0;
    @(posedge CLK); #1;
    cv[0] = 1'b0;
    rst = 1'b1;
    @(posedge CLK); #1;
    rst = 1'b0;
    clear_models();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (done[0]) pulses++;
      @(posedge CLK); #1;
    end
    check("midrst_no_done", pulses, 0);
    check("midrst_reg_a", 32'(ra[0]), 32'd0);
    check("midrst_reg_b", 32'(rb[0]), 32'd0);
    check("midrst_opcode", 32'(aop[0]), 32'hF);
    check("midrst_ready", 32'(rdy[0]), 32'd1);
    do_cmd(0, 1'b0, 4'h5, 1'b0, 8'h00);   // INC A from clean state -> 01

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Operand-holding issue stage that sits directly upstream of the 8-bit ALU. It accepts commands over a valid/ready handshake and keeps two 8-bit operand registers, A and B. Each command either loads an immediate into A or B, or issues an ALU operation. For an issued operation it drives the ALU's IN_A, IN_B and ALU_Op_Code inputs, waits a fixed ALU latency, then captures the ALU Out result back into A or B.

## Interface
Parameters:
- ALU_LATENCY, 1: number of clock edges between ALU inputs becoming valid and ALU Out becoming valid (0 = combinational ALU).

Ports:
- CLK  in  1  single clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  unit can accept a command this cycle.
- CMD_LOAD  in  1  1 = load CMD_IMM into destination; 0 = ALU operation.
- CMD_OP  in  4  ALU opcode, used when CMD_LOAD=0.
- CMD_DST  in  1  destination register: 0 = A, 1 = B.
- CMD_IMM  in  8  immediate value for loads.
- ALU_IN_A  out  8  to ALU IN_A.
- ALU_IN_B  out  8  to ALU IN_B.
- ALU_OP_CODE  out  4  to ALU ALU_Op_Code.
- ALU_OUT  in  8  from ALU Out.
- REG_A  out  8  current operand register A.
- REG_B  out  8  current operand register B.
- RESULT  out  8  last captured ALU result.
- DONE  out  1  one-cycle pulse when a command completes.

## Operation
Opcodes:
- 0x0 ADD, 0x1 SUB (A−B), 0x2 MUL (low 8 bits), 0x3 SHL A, 0x4 SHR A.
- 0x5 INC A, 0x6 INC B, 0x7 DEC A, 0x8 DEC B.
- 0x9 EQ, 0xA GT, 0xB LT: result 0x01 or 0x00.
- 0xC–0xE reserved; 0xF NOP.

Handshake:
- A command is accepted on a rising edge where CMD_VALID && CMD_READY.
- Upstream holds all CMD_* fields stable while CMD_VALID=1 and CMD_READY=0.

State machine: IDLE, EXEC.
- IDLE: CMD_READY=1; ALU_OP_CODE=0xF.
- IDLE, accepted load: destination register ← CMD_IMM on the accept edge; DONE=1 in the following cycle; state stays IDLE.
- IDLE, accepted NOP or reserved opcode: no register change; DONE=1 in the following cycle; stays IDLE; ALU_OP_CODE remains 0xF.
- IDLE, accepted opcode 0x0–0xB, on the accept edge:
  - ALU_IN_A ← REG_A, ALU_IN_B ← REG_B, ALU_OP_CODE ← CMD_OP.
  - Latch CMD_DST; latency counter ← ALU_LATENCY; go to EXEC.
- EXEC: CMD_READY=0; ALU_* outputs held.
  - If counter ≠ 0: decrement.
  - If counter = 0: on that edge, destination register ← ALU_OUT and RESULT ← ALU_OUT; DONE=1 in the following cycle; ALU_OP_CODE ← 0xF; go to IDLE.
- Width rules: ALU_OUT is stored unmodified; no carry or overflow flags are kept.
- Operands are sampled at acceptance. A load that follows an issue cannot affect that in-flight operation.

## Timing
- Reset values: REG_A=0, REG_B=0, RESULT=0, ALU_IN_A=0, ALU_IN_B=0, ALU_OP_CODE=0xF, DONE=0, state IDLE. CMD_READY=1 in the first cycle after RESET deasserts.
- Load and NOP: accept at edge E0; DONE high in cycle E0→E1; a new command can be accepted at E1 (back-to-back, one per cycle).
- ALU operation: accept at E0; capture at edge E0+ALU_LATENCY+1; DONE high for one cycle after the capture; next accept no earlier than the capture edge +1.
- DONE is registered and is never high for two consecutive cycles for the same command.
- RESET asserted in any state, including mid-EXEC, forces all reset values on that edge. The in-flight result is discarded and no DONE is produced.
- CMD_VALID during EXEC is ignored until IDLE; no command is queued or dropped.

## Structure
- Shared package alu_pkg holds:
  - Opcode constants ALU_ADD … ALU_LT and ALU_NOP = 4'hF.
  - Reserved range bounds.
  - FSM state encoding.
  - Data width constant (8).
- The ALU opcode constants are shared with the ALU itself.
- One sub-module, alu_operand_regs: the A/B register pair with write-enable, write-select and write-data ports, plus synchronous reset.
- The FSM, latency counter and ALU output registers stay in alu_issue_unit.

## Test plan
- Reset: assert RESET for 3 cycles → REG_A=REG_B=RESULT=0x00, ALU_OP_CODE=0xF, DONE=0, CMD_READY=1 after release.
- Load A=0x05, load B=0x03 back-to-back, then ADD dst A with a registered ALU model (latency 1) → REG_A=0x08, RESULT=0x08, DONE exactly 2 cycles after accept, CMD_READY=0 during EXEC.
- With A=0x08, B=0x03: SUB dst B → REG_B=0x05; then GT dst A → REG_A=0x01; then LT dst B (A=0x01, B=0x05) → REG_B=0x01.
- Hold CMD_VALID with INC A during EXEC of MUL (A=0x02, B=0x03, dst A) → INC is not accepted until IDLE; REG_A goes 0x06 then 0x07; DONE pulses exactly twice.
- Assert RESET one cycle after issuing ADD → no DONE; REG_A=REG_B=0x00; ALU_OP_CODE=0xF.
- Issue opcode 0xC and 0xF with A=0x05 → DONE the cycle after each accept, REG_A stays 0x05, ALU_OP_CODE stays 0xF. Repeat the ADD case with ALU_LATENCY=0 and a combinational model → DONE 1 cycle after accept.
